// File: rtl/reg_status_file_pkg.sv
// Shared definitions for the register status file (Tomasulo-style rename table).
// Holds the default geometry, the "no producer" tag value, and the
// reg-status entry layout used when reasoning about one register slot.
package reg_status_file_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NREGS_DEF  = 8;
  localparam int TAG_W_DEF  = 3;

  // A qi of zero means the register value is architecturally final.
  localparam int TAG_NONE   = 0;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [TAG_W_DEF-1:0]  qi;
  } rs_entry_t;

endpackage

// File: rtl/reg_status_file_rs_read_port.sv
// rs_read_port: one combinational operand read port of the register status file.
// Ports:
//   i_addr        register index to read
//   i_data/i_qi   full stored data and producer-tag arrays
//   i_cdb_*       current-cycle common data bus (used only for forwarding)
//   o_data/o_busy/o_tag  operand value, pending flag, producer tag
// Build option: REG_STATUS_BYPASS_EN forwards a same-cycle CDB result that
// matches the pending producer of the addressed register.
module rs_read_port
  import reg_status_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_data [NREGS],
  input  logic [TAG_W-1:0]  i_qi   [NREGS],
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic [TAG_W-1:0]  o_tag
);

`ifndef REG_STATUS_BYPASS_EN
  // CDB inputs are only consumed by the forwarding mux.
  logic w_unused_cdb;
  assign w_unused_cdb = &{1'b0, i_cdb_valid, i_cdb_tag, i_cdb_data};
`endif

  always_comb begin
    o_data = '0;
    o_tag  = '0;
    if (int'(i_addr) < NREGS) begin
      o_data = i_data[i_addr];
      o_tag  = i_qi[i_addr];
    end
`ifdef REG_STATUS_BYPASS_EN
    // A nonzero stored tag equal to the broadcast tag means the value being
    // waited on is on the bus right now.
    if (i_cdb_valid && (o_tag != TAG_W'(TAG_NONE)) && (o_tag == i_cdb_tag)) begin
      o_data = i_cdb_data;
      o_tag  = '0;
    end
`endif
    o_busy = (o_tag != TAG_W'(TAG_NONE));
  end

endmodule

// File: rtl/reg_status_file.sv
// reg_status_file: register data + producer-tag (qi) table with rename on
// issue, wake-up on CDB broadcast, two combinational read ports and a
// registered busy count.
// Ports:
//   clock, reset_n                 sole clock; synchronous active-low reset
//   issue_valid/issue_rd/issue_tag rename destination register to a tag
//   cdb_valid/cdb_tag/cdb_data     result broadcast
//   rd_a_*, rd_b_*                 operand read ports (addr in; data/busy/tag out)
//   busy_cnt                       number of registers with a pending producer
// Build option: REG_STATUS_BYPASS_EN enables same-cycle CDB forwarding on reads.
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  localparam int IDX_W = $clog2(NREGS),
  localparam int CNT_W = $clog2(NREGS + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [IDX_W-1:0]  issue_rd,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [IDX_W-1:0]  rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic              rd_a_busy,
  output logic [TAG_W-1:0]  rd_a_tag,
  input  logic [IDX_W-1:0]  rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              rd_b_busy,
  output logic [TAG_W-1:0]  rd_b_tag,
  output logic [CNT_W-1:0]  busy_cnt
);

  logic [DATA_W-1:0] r_data [NREGS];
  logic [TAG_W-1:0]  r_qi   [NREGS];
  logic [CNT_W-1:0]  r_busy_cnt;

  logic [DATA_W-1:0] w_data_nxt [NREGS];
  logic [TAG_W-1:0]  w_qi_nxt   [NREGS];
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_cdb_hit;
  logic              w_issue_ok;

  assign w_cdb_hit  = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));
  assign w_issue_ok = issue_valid && (issue_tag != TAG_W'(TAG_NONE)) &&
                      (issue_rd != '0) && (int'(issue_rd) < NREGS);

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_data_nxt[i] = r_data[i];
      w_qi_nxt[i]   = r_qi[i];
      if (i == 0) begin
        // Register 0 is hardwired to zero and never renamed.
        w_data_nxt[i] = '0;
        w_qi_nxt[i]   = '0;
      end else begin
        if (w_cdb_hit && (r_qi[i] == cdb_tag)) begin
          w_data_nxt[i] = cdb_data;
          w_qi_nxt[i]   = '0;
        end
        // Applied after the CDB wake-up so a same-cycle rename keeps the new
        // producer while the broadcast value still lands in data.
        if (w_issue_ok && (int'(issue_rd) == i)) begin
          w_qi_nxt[i] = issue_tag;
        end
      end
      if (w_qi_nxt[i] != TAG_W'(TAG_NONE)) begin
        w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_data[i] <= '0;
        r_qi[i]   <= '0;
      end
      r_busy_cnt <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        r_data[i] <= w_data_nxt[i];
        r_qi[i]   <= w_qi_nxt[i];
      end
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  rs_read_port #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .TAG_W  (TAG_W)
  ) u_rd_a (
    .i_addr      (rd_a_addr),
    .i_data      (r_data),
    .i_qi        (r_qi),
    .i_cdb_valid (cdb_valid),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_data  (cdb_data),
    .o_data      (rd_a_data),
    .o_busy      (rd_a_busy),
    .o_tag       (rd_a_tag)
  );

  rs_read_port #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .TAG_W  (TAG_W)
  ) u_rd_b (
    .i_addr      (rd_b_addr),
    .i_data      (r_data),
    .i_qi        (r_qi),
    .i_cdb_valid (cdb_valid),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_data  (cdb_data),
    .o_data      (rd_b_data),
    .o_busy      (rd_b_busy),
    .o_tag       (rd_b_tag)
  );

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: the driver applies one directed vector
// per cycle and queues the hand-computed read/busy_cnt values for that cycle;
// the monitor pops and compares mid-cycle whenever a vector is flagged valid.
module tb_reg_status_file;
  import reg_status_file_pkg::*;

`ifdef REG_STATUS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [2:0]  issue_rd;
  logic [2:0]  issue_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [2:0]  rd_a_addr;
  logic [15:0] rd_a_data;
  logic        rd_a_busy;
  logic [2:0]  rd_a_tag;
  logic [2:0]  rd_b_addr;
  logic [15:0] rd_b_data;
  logic        rd_b_busy;
  logic [2:0]  rd_b_tag;
  logic [3:0]  busy_cnt;

  reg_status_file dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .rd_a_addr   (rd_a_addr),
    .rd_a_data   (rd_a_data),
    .rd_a_busy   (rd_a_busy),
    .rd_a_tag    (rd_a_tag),
    .rd_b_addr   (rd_b_addr),
    .rd_b_data   (rd_b_data),
    .rd_b_busy   (rd_b_busy),
    .rd_b_tag    (rd_b_tag),
    .busy_cnt    (busy_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int        step;
    rs_entry_t a;
    rs_entry_t b;
    int        cnt;
  } exp_t;

  exp_t exp_q[$];
  logic mon_valid = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   step_no   = 0;

  task automatic cmp(input string name, input int step, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, step, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (mon_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow step=%0d got=0 want=1", step_no);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("rd_a_data", e.step, int'(rd_a_data), int'(e.a.data));
        cmp("rd_a_tag",  e.step, int'(rd_a_tag),  int'(e.a.qi));
        cmp("rd_a_busy", e.step, int'(rd_a_busy), int'(e.a.qi != 3'd0));
        cmp("rd_b_data", e.step, int'(rd_b_data), int'(e.b.data));
        cmp("rd_b_tag",  e.step, int'(rd_b_tag),  int'(e.b.qi));
        cmp("rd_b_busy", e.step, int'(rd_b_busy), int'(e.b.qi != 3'd0));
        cmp("busy_cnt",  e.step, int'(busy_cnt),  e.cnt);
      end
    end
  end

  // One cycle of stimulus. Expected values describe what the read ports show
  // during this cycle (state from the previous edge, plus forwarding if built in).
  task automatic step(input logic rst_v,
                      input logic iv, input int ird, input int itag,
                      input logic cv, input int ctag, input logic [15:0] cd,
                      input int ra, input int rb, input logic chk,
                      input logic [15:0] ad, input int at,
                      input logic [15:0] bd, input int bt, input int cnt);
    exp_t e;
    @(posedge clock);
    #1;
    step_no++;
    reset_n     = rst_v;
    issue_valid = iv;
    issue_rd    = ird[2:0];
    issue_tag   = itag[2:0];
    cdb_valid   = cv;
    cdb_tag     = ctag[2:0];
    cdb_data    = cd;
    rd_a_addr   = ra[2:0];
    rd_b_addr   = rb[2:0];
    if (chk) begin
      e.step    = step_no;
      e.a.data  = ad;
      e.a.qi    = at[2:0];
      e.b.data  = bd;
      e.b.qi    = bt[2:0];
      e.cnt     = cnt;
      exp_q.push_back(e);
    end
    mon_valid = chk;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout want=finish", step_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; rd_a_addr = '0; rd_b_addr = '0;

    //   rst iv rd tg  cv tg data      ra rb chk  a_data    a_tg b_data    b_tg cnt
    step(0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    step(0, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    // Reset state: every register reads zero
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 0, 0, 0, 16'h0000, i, i + 4, 1, 16'h0000, 0, 16'h0000, 0, 0);

    // Rename r3 to tag 5, then wake it up
    step(1, 1, 3, 5,  0, 0, 16'h0000, 3, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 3, 3, 1, 16'h0000, 5, 16'h0000, 5, 1);
    step(1, 0, 0, 0,  1, 5, 16'h00AB, 3, 0, 1,
         BYP ? 16'h00AB : 16'h0000, BYP ? 0 : 5, 16'h0000, 0, 1);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 3, 0, 1, 16'h00AB, 0, 16'h0000, 0, 0);

    // Two registers waiting on the same tag
    step(1, 1, 2, 2,  0, 0, 16'h0000, 2, 4, 1, 16'h0000, 0, 16'h0000, 0, 0);
    step(1, 1, 4, 2,  0, 0, 16'h0000, 2, 4, 1, 16'h0000, 2, 16'h0000, 0, 1);
    step(1, 0, 0, 0,  1, 2, 16'h1234, 2, 4, 1,
         BYP ? 16'h1234 : 16'h0000, BYP ? 0 : 2,
         BYP ? 16'h1234 : 16'h0000, BYP ? 0 : 2, 2);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 2, 4, 1, 16'h1234, 0, 16'h1234, 0, 0);

    // Same-cycle wake-up and re-rename of r6: data from CDB, new producer kept
    step(1, 1, 6, 1,  0, 0, 16'h0000, 6, 3, 1, 16'h0000, 0, 16'h00AB, 0, 0);
    step(1, 1, 6, 4,  1, 1, 16'h0F0F, 6, 3, 1,
         BYP ? 16'h0F0F : 16'h0000, BYP ? 0 : 1, 16'h00AB, 0, 1);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 6, 3, 1, 16'h0F0F, 4, 16'h00AB, 0, 1);

    // Port B forwarding case on r1
    step(1, 1, 1, 7,  0, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 1);
    step(1, 0, 0, 0,  1, 7, 16'hBEEF, 6, 1, 1, 16'h0F0F, 4,
         BYP ? 16'hBEEF : 16'h0000, BYP ? 0 : 7, 2);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 1, 1, 1, 16'hBEEF, 0, 16'hBEEF, 0, 1);

    // Ignored operations: issue to r0, issue with tag 0, CDB tag 0, unmatched tag
    step(1, 1, 0, 3,  0, 0, 16'h0000, 0, 6, 1, 16'h0000, 0, 16'h0F0F, 4, 1);
    step(1, 1, 5, 0,  0, 0, 16'h0000, 0, 5, 1, 16'h0000, 0, 16'h0000, 0, 1);
    step(1, 0, 0, 0,  1, 0, 16'hFFFF, 5, 0, 1, 16'h0000, 0, 16'h0000, 0, 1);
    step(1, 0, 0, 0,  1, 3, 16'h5555, 0, 6, 1, 16'h0000, 0, 16'h0F0F, 4, 1);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 0, 5, 1, 16'h0000, 0, 16'h0000, 0, 1);

    // Reset while renames are pending; issue and CDB in that cycle are dropped
    step(1, 1, 2, 3,  0, 0, 16'h0000, 2, 6, 1, 16'h1234, 0, 16'h0F0F, 4, 1);
    step(0, 1, 7, 5,  1, 4, 16'h7777, 2, 6, 1, 16'h1234, 3,
         BYP ? 16'h7777 : 16'h0F0F, BYP ? 0 : 4, 2);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 2, 6, 1, 16'h0000, 0, 16'h0000, 0, 0);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 7, 3, 1, 16'h0000, 0, 16'h0000, 0, 0);
    step(1, 0, 0, 0,  0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);

    repeat (2) @(posedge clock);
    cmp("scoreboard_drained", step_no, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
